data_mem_responder: RTL and testbench

Responder end of the CPU data-memory port. Accepts one load or store request at a time from the memory stage and holds it for a configurable number of wait states. It then returns one response pulse, the completion that the memory stage consumes as mem_done. It owns a word-organised storage array and does byte/half/word lane steering, sign/zero extension, and misalignment and range checking.

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: single outstanding load/store,
// fixed wait states, word array with byte/half lane steering and extension.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, stateNxt;
  logic [3:0]  cnt, cntNxt;
  logic        accept, enterResp;

  logic        latWrite, latUnsigned;
  logic [1:0]  latSize;
  logic [31:0] latAddr, latWdata;

  logic        curWrite, curUnsigned, curErr, doStore;
  logic [1:0]  curSize;
  logic [31:0] curAddr, curWdata, storeData;
  logic [AW-1:0] curIdx;
  logic [3:0]  curMask;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdataReg;
  logic        errReg;

  function automatic logic accessError(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) ||
           (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) ||
           ({1'b0, addr} >= ADDR_LIMIT);
  endfunction

  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used in IDLE and the latched copy everywhere else.
  assign curWrite    = (state == IDLE) ? req_write    : latWrite;
  assign curSize     = (state == IDLE) ? req_size     : latSize;
  assign curUnsigned = (state == IDLE) ? req_unsigned : latUnsigned;
  assign curAddr     = (state == IDLE) ? req_addr     : latAddr;
  assign curWdata    = (state == IDLE) ? req_wdata    : latWdata;

  assign curErr  = accessError(curSize, curAddr);
  assign curIdx  = curAddr[AW+1:2];
  assign curMask = laneMask(curSize, curAddr[1:0]);
  assign doStore = enterResp && curWrite && !curErr;

  always_comb begin
    case (curSize)
      2'b00:   storeData = {4{curWdata[7:0]}};
      2'b01:   storeData = {2{curWdata[15:0]}};
      default: storeData = curWdata;
    endcase
  end

  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enterResp  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            stateNxt  = RESP;
            enterResp = 1'b1;
          end else begin
            stateNxt = WAIT;
            cntNxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          stateNxt  = RESP;
          enterResp = 1'b1;
        end else begin
          cntNxt = cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNxt   = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Control stage: state and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Data stage: request capture, array access and response data
  always_ff @(posedge clk) begin
    if (accept) begin
      latWrite    <= req_write;
      latSize     <= req_size;
      latUnsigned <= req_unsigned;
      latAddr     <= req_addr;
      latWdata    <= req_wdata;
    end
    if (enterResp) begin
      errReg   <= curErr;
      rdataReg <= (curErr || curWrite) ? 32'd0
                  : extendLoad(mem[curIdx], curSize, curAddr[1:0], curUnsigned);
    end
    if (doStore) begin
      for (int i = 0; i < 4; i++) begin
        if (curMask[i]) mem[curIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  assign resp_rdata = resp_valid ? rdataReg : 32'd0;
  assign resp_error = resp_valid ? errReg   : 1'b0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance for the main
// function and one LATENCY=0 instance for the zero-wait-state timing.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata, respRdata;
  logic        respValid, respError;

  logic        reqValidZ, reqReadyZ, reqWriteZ, reqUnsignedZ;
  logic [1:0]  reqSizeZ;
  logic [31:0] reqAddrZ, reqWdataZ, respRdataZ;
  logic        respValidZ, respErrorZ;

  int nCmp = 0;
  int nBad = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
    .req_wdata(reqWdata), .resp_valid(respValid), .resp_rdata(respRdata),
    .resp_error(respError)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dutZ (
    .clk(clk), .rst(rst),
    .req_valid(reqValidZ), .req_ready(reqReadyZ), .req_write(reqWriteZ),
    .req_size(reqSizeZ), .req_unsigned(reqUnsignedZ), .req_addr(reqAddrZ),
    .req_wdata(reqWdataZ), .resp_valid(respValidZ), .resp_rdata(respRdataZ),
    .resp_error(respErrorZ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance; req_valid stays high through
  // WAIT, and with scramble the address/data are altered after acceptance.
  task automatic doReq(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic scramble,
                       output logic [31:0] rd, output logic er);
    int n;
    check({tag, "_ready"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = uns;
    reqAddr = a; reqWdata = d;
    @(posedge clk); #1;
    n = 1;
    if (scramble) begin
      reqAddr  = a + 32'h4;
      reqWdata = ~d;
    end
    while (!respValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    reqValid = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'd3);
    rd = respRdata;
    er = respError;
    @(posedge clk); #1;
  endtask

  task automatic expectReq(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d, input logic scramble,
                           input logic [31:0] expRd, input logic expErr);
    logic [31:0] rd;
    logic er;
    doReq(tag, w, sz, uns, a, d, scramble, rd, er);
    check({tag, "_rdata"}, rd, expRd);
    check({tag, "_err"}, 32'(er), 32'(expErr));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'd0; reqWdata = 32'd0;
    reqValidZ = 1'b0; reqWriteZ = 1'b0; reqSizeZ = 2'b00; reqUnsignedZ = 1'b0;
    reqAddrZ = 32'd0; reqWdataZ = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(reqReady), 32'd0);
    check("rst_valid", 32'(respValid), 32'd0);
    check("rst_rdata", respRdata, 32'd0);
    check("rst_err", 32'(respError), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // word store then load
    expectReq("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    expectReq("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // sub-word lanes and extension
    expectReq("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b0);
    expectReq("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, 1'b0, 32'h0, 1'b0);
    expectReq("ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1122AB44, 1'b0);
    expectReq("ld_b21s", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'hFFFFFFAB, 1'b0);
    expectReq("ld_b21u", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'h000000AB, 1'b0);
    expectReq("ld_h22s", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'h00001122, 1'b0);
    expectReq("ld_h20s", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFFAB44, 1'b0);
    expectReq("ld_h20u", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000AB44, 1'b0);
    expectReq("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF5566, 1'b0, 32'h0, 1'b0);
    expectReq("ld_w20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5566AB44, 1'b0);
    expectReq("ld_b23s", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, 32'h00000055, 1'b0);
    expectReq("ld_b20u", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00000044, 1'b0);

    // error cases
    expectReq("ld_w13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b1);
    expectReq("st_h21", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, 1'b0, 32'h0, 1'b1);
    expectReq("ld_w20c", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5566AB44, 1'b0);
    expectReq("st_sz3", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
    expectReq("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
    expectReq("ld_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1);
    expectReq("st_410", 1'b1, 2'b10, 1'b0, 32'h410, 32'h0, 1'b0, 32'h0, 1'b1);
    expectReq("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    expectReq("st_3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5C3C3, 1'b0, 32'h0, 1'b0);
    expectReq("ld_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA5A5C3C3, 1'b0);

    // input changes during WAIT are ignored
    expectReq("st_w54", 1'b1, 2'b10, 1'b0, 32'h54, 32'h12345678, 1'b0, 32'h0, 1'b0);
    expectReq("st_w50x", 1'b1, 2'b10, 1'b0, 32'h50, 32'h0BADF00D, 1'b1, 32'h0, 1'b0);
    expectReq("ld_w50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0BADF00D, 1'b0);
    expectReq("ld_w54", 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, 1'b0, 32'h12345678, 1'b0);
    expectReq("ld_w50x", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);

    // reset during WAIT drops a pending store
    expectReq("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h01020304, 1'b0, 32'h0, 1'b0);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqAddr = 32'h30; reqWdata = 32'h55;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstw_ready", 32'(reqReady), 32'd0);
    check("rstw_valid", 32'(respValid), 32'd0);
    @(posedge clk); #1;
    check("rstw_valid2", 32'(respValid), 32'd0);
    check("rstw_ready2", 32'(reqReady), 32'd0);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (respValid) seen++;
    end
    check("rstw_noresp", 32'(seen), 32'd0);
    expectReq("ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h01020304, 1'b0);

    // zero wait states: held req_valid is accepted every second cycle
    reqValidZ = 1'b1; reqWriteZ = 1'b1; reqSizeZ = 2'b10; reqAddrZ = 32'h40;
    reqWdataZ = 32'hCAFEF00D;
    check("z_ready0", 32'(reqReadyZ), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("z_valid%0d", k), 32'(respValidZ), 32'((k % 2) == 0));
      check($sformatf("z_ready%0d", k), 32'(reqReadyZ), 32'((k % 2) == 1));
    end
    reqValidZ = 1'b0;
    @(posedge clk); #1;
    check("z_idle", 32'(respValidZ), 32'd0);
    reqValidZ = 1'b1; reqWriteZ = 1'b0; reqSizeZ = 2'b00; reqUnsignedZ = 1'b0;
    reqAddrZ = 32'h43;
    @(posedge clk); #1;
    reqValidZ = 1'b0;
    check("z_ld_valid", 32'(respValidZ), 32'd1);
    check("z_ld_rdata", respRdataZ, 32'hFFFFFFCA);
    check("z_ld_err", 32'(respErrorZ), 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
